booth_mult_arbiter: RTL and testbench

Round-robin controller that shares one sequential 32x32 signed Booth multiplier between NREQ requesters. It accepts one request at a time over a valid/ready handshake and latches its operands. It then sequences the multiplier through clear, settle and run phases, and watches for the multiplier's done pulse. It returns the 64-bit product tagged with the requester index, and uses a watchdog to cover a multiplier that never finishes.

---
 rtl/booth_mult_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// ============================================================================
// booth_mult_arbiter
//
// Purpose:
//   Round-robin front end that shares one sequential 32x32 signed Booth
//   multiplier between NREQ requesters. One request at a time is accepted
//   over a valid/ready handshake and its operands are latched. The multiplier
//   is then walked through a clear cycle, a post-clear settle cycle and a run
//   phase that lasts until its done pulse. The 64-bit product is returned
//   tagged with the requester index. A watchdog abandons the run phase if the
//   multiplier never reports done. In that case the response carries no
//   product and rsp_timeout is set.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   IDW      width of a requester index (clog2 NREQ)
//   TIMEOUT  maximum number of run-phase cycles before the operation is dropped
//
// Ports:
//   clk          in   clock, all logic on the rising edge
//   reset        in   asynchronous active-low reset (0 = reset asserted)
//   req_valid    in   [NREQ]      per-requester request valid
//   req_m        in   [NREQ*32]   multiplicands, requester i at [32i+31:32i]
//   req_q        in   [NREQ*32]   multipliers, same packing
//   req_ready    out  [NREQ]      one-hot, single-cycle acceptance pulse
//   rsp_valid    out              response valid, held until rsp_ready
//   rsp_ready    in               response consumer ready
//   rsp_id       out  [IDW]       requester index the response belongs to
//   rsp_result   out  [64]        signed product m*q (0 on timeout)
//   rsp_timeout  out              response abandoned by the watchdog
//   mul_m        out  [32]        multiplier operand m
//   mul_q        out  [32]        multiplier operand q
//   mul_en       out              multiplier enable
//   mul_reset    out              multiplier synchronous active-high clear
//   mul_result   in   [64]        multiplier product
//   mul_done     in               multiplier done pulse
//   busy         out              high in every state except IDLE
// ============================================================================
module booth_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_m,
    input  logic [NREQ*32-1:0] req_q,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [63:0]        rsp_result,
    output logic               rsp_timeout,
    output logic [31:0]        mul_m,
    output logic [31:0]        mul_q,
    output logic               mul_en,
    output logic               mul_reset,
    input  logic [63:0]        mul_result,
    input  logic               mul_done,
    output logic               busy
);

    // One extra bit over clog2 so TIMEOUT-1 always fits with headroom.
    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SETTLE,
        S_RUN,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDW-1:0]  ptr;
    logic [WDW-1:0]  wd_cnt;

    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] upper_mask;
    logic [NREQ-1:0] upper_valid;
    logic [31:0]     sel_m;
    logic [31:0]     sel_q;
    logic            wd_expire;

    // ------------------------------------------------------------------------
    // Round-robin grant. Requesters above the pointer have priority. The
    // lowest of them wins. If none of them is valid, the search wraps and the
    // lowest valid requester overall wins. Each scan runs downward so that
    // the last assignment, which is the lowest index, sticks.
    // ------------------------------------------------------------------------
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper_mask[i] = (i > int'(ptr));
        end
        upper_valid = req_valid & upper_mask;
        grant_any   = |req_valid;
        grant_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_idx = IDW'(i);
            end
        end
        if (|upper_valid) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (upper_valid[i]) begin
                    grant_idx = IDW'(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Operand mux for the grantee. This is an explicit compare-and-select,
    // so no variable part-select is needed on the packed request buses.
    // ------------------------------------------------------------------------
    always_comb begin
        sel_m = '0;
        sel_q = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_m = req_m[i*32 +: 32];
                sel_q = req_q[i*32 +: 32];
            end
        end
    end

    assign wd_expire = (wd_cnt == WDW'(TIMEOUT - 1));

    // ------------------------------------------------------------------------
    // Next-state and state-decoded outputs. The acceptance pulse is gated
    // with reset. Without the gate, a requester holding valid while reset is
    // asserted would see req_ready, because IDLE is also the reset state.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        mul_en    = 1'b0;
        mul_reset = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (grant_any && reset) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = S_CLR;
                end
            end
            S_CLR: begin
                mul_en    = 1'b1;
                mul_reset = 1'b1;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                mul_en    = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                mul_en = 1'b1;
                if (mul_done || wd_expire) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register. The pointer resets to NREQ-1 so that requester 0 is
    // the first in line after reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Accept path. On the accept edge, capture the grantee's operands and
    // index, and move the pointer to it. The operands then stay untouched
    // until the next accept, so the multiplier sees stable inputs through
    // the response.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= IDW'(NREQ - 1);
            mul_m  <= '0;
            mul_q  <= '0;
            rsp_id <= '0;
        end else if (state == S_IDLE && grant_any) begin
            ptr    <= grant_idx;
            mul_m  <= sel_m;
            mul_q  <= sel_q;
            rsp_id <= grant_idx;
        end
    end

    // ------------------------------------------------------------------------
    // Watchdog and result capture. The counter is zeroed in SETTLE, so it
    // reads 0 in the first RUN cycle. A done pulse is checked before the
    // watchdog, so a done on the final permitted cycle still delivers the
    // product.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= '0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_SETTLE: begin
                    wd_cnt <= '0;
                end
                S_RUN: begin
                    wd_cnt <= wd_cnt + WDW'(1);
                    if (mul_done) begin
                        rsp_result  <= mul_result;
                        rsp_timeout <= 1'b0;
                    end else if (wd_expire) begin
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// ============================================================================
// tb_booth_mult_arbiter
//
// Drives directed requests into booth_mult_arbiter against a multiplier stub.
// A transaction-level model predicts every output on every cycle. Directed
// tasks additionally pin literal products, latencies and grant order.
// ============================================================================
module tb_booth_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 40;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_m;
    logic [NREQ*32-1:0] req_q;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_result;
    logic               rsp_timeout;
    logic [31:0]        mul_m;
    logic [31:0]        mul_q;
    logic               mul_en;
    logic               mul_reset;
    logic [63:0]        mul_result;
    logic               mul_done;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    booth_mult_arbiter #(
        .NREQ   (NREQ),
        .IDW    (IDW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_m      (req_m),
        .req_q      (req_q),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_timeout(rsp_timeout),
        .mul_m      (mul_m),
        .mul_q      (mul_q),
        .mul_en     (mul_en),
        .mul_reset  (mul_reset),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------------
    // Multiplier stub. It counts enabled cycles after a clear. The settle
    // cycle leaves the count at 1 for RUN cycle 0, so a count of 33 marks the
    // 33rd RUN cycle, which is the team multiplier's nominal finish.
    // ------------------------------------------------------------------------
    int stub_cnt     = 0;
    int stub_done_at = 33;
    bit stub_done_en = 1'b1;

    always @(posedge clk) begin
        if (mul_en && mul_reset) stub_cnt <= 0;
        else if (mul_en)         stub_cnt <= stub_cnt + 1;
    end

    assign mul_done   = stub_done_en && mul_en && (stub_cnt == stub_done_at);
    assign mul_result = longint'($signed(mul_m)) * longint'($signed(mul_q));

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction model: idle / busy with a count of cycles since the accept
    // edge / response. It is advanced once per cycle from the values that
    // will be present at the coming rising edge.
    // ------------------------------------------------------------------------
    typedef enum {M_IDLE, M_BUSY, M_RESP} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int          m_age  = 0;
    int          m_ptr  = NREQ - 1;
    int          m_id   = 0;
    logic [31:0] m_m    = '0;
    logic [31:0] m_q    = '0;
    logic [63:0] m_res  = '0;
    bit          m_to   = 1'b0;

    function automatic int model_grant();
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (m_ptr + i) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check_output("rst_req_ready", 64'(req_ready), 64'd0);
            check_output("rst_busy", 64'(busy), 64'd0);
            check_output("rst_mul_en", 64'(mul_en), 64'd0);
            check_output("rst_mul_reset", 64'(mul_reset), 64'd0);
            check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check_output("rst_rsp_result", rsp_result, 64'd0);
            check_output("rst_mul_m", 64'(mul_m), 64'd0);
            m_mode = M_IDLE;
            m_ptr  = NREQ - 1;
        end else begin
            int g;
            logic [63:0] exp_ready;
            g         = (m_mode == M_IDLE) ? model_grant() : -1;
            exp_ready = (g >= 0) ? (64'd1 << g) : 64'd0;
            check_output("req_ready", 64'(req_ready), exp_ready);
            check_output("busy", 64'(busy), 64'(m_mode != M_IDLE));
            check_output("mul_en", 64'(mul_en), 64'(m_mode == M_BUSY));
            check_output("mul_reset", 64'(mul_reset), 64'(m_mode == M_BUSY && m_age == 1));
            check_output("rsp_valid", 64'(rsp_valid), 64'(m_mode == M_RESP));
            if (m_mode != M_IDLE) begin
                check_output("mul_m", 64'(mul_m), 64'(m_m));
                check_output("mul_q", 64'(mul_q), 64'(m_q));
            end
            if (m_mode == M_RESP) begin
                check_output("rsp_id", 64'(rsp_id), 64'(m_id));
                check_output("rsp_result", rsp_result, m_res);
                check_output("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
            end
            case (m_mode)
                M_IDLE: if (g >= 0) begin
                    m_mode = M_BUSY;
                    m_age  = 1;
                    m_ptr  = g;
                    m_id   = g;
                    m_m    = req_m[g*32 +: 32];
                    m_q    = req_q[g*32 +: 32];
                end
                M_BUSY: begin
                    if (m_age >= 3 && mul_done) begin
                        m_mode = M_RESP;
                        m_res  = longint'($signed(m_m)) * longint'($signed(m_q));
                        m_to   = 1'b0;
                    end else if (m_age >= 3 && (m_age - 3) == TIMEOUT - 1) begin
                        m_mode = M_RESP;
                        m_res  = '0;
                        m_to   = 1'b1;
                    end else begin
                        m_age++;
                    end
                end
                M_RESP: if (rsp_ready) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after a rising edge. Waits
    // on the DUT are bounded, and an expired bound counts as a miscompare.
    // ------------------------------------------------------------------------
    task automatic apply_stimulus(input int id, input logic [31:0] m, input logic [31:0] q);
        @(posedge clk); #1;
        req_valid[id]     = 1'b1;
        req_m[id*32 +: 32] = m;
        req_q[id*32 +: 32] = q;
    endtask

    task automatic drop_req(input int id);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_ready(input int id, output int c);
        bit ok;
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                c  = cyc;
            end
        end
        check_output($sformatf("wait_ready%0d", id), 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp(output int c);
        bit ok;
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                c  = cyc;
            end
        end
        check_output("wait_rsp", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        check_output("wait_idle", 64'(ok), 64'd1);
    endtask

    task automatic do_op(input int id, input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] exp_res, input bit exp_to, input int exp_lat,
                         input string name);
        int t0;
        int t1;
        apply_stimulus(id, m, q);
        wait_ready(id, t0);
        drop_req(id);
        wait_rsp(t1);
        check_output({name, "_latency"}, 64'(t1 - t0), 64'(exp_lat));
        check_output({name, "_id"}, 64'(rsp_id), 64'(id));
        check_output({name, "_result"}, rsp_result, exp_res);
        check_output({name, "_timeout"}, 64'(rsp_timeout), 64'(exp_to));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int order[$];
        int exp_order[6];
        int t0;
        int t1;
        logic [63:0] held;

        exp_order = '{0, 1, 3, 0, 1, 3};
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_m[i*32 +: 32] = 32'(i + 5);
            req_q[i*32 +: 32] = 32'(-(i + 2));
        end
        #1 reset = 1'b0;
        req_valid = 4'b1011;
        #1;
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_req_ready", 64'(req_ready), 64'd0);
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Round-robin order with 0, 1 and 3 held valid from reset.
        for (int i = 0; i < 600 && order.size() < 6; i++) begin
            @(negedge clk);
            for (int j = 0; j < NREQ; j++) begin
                if (req_ready[j]) order.push_back(j);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            check_output($sformatf("grant_order[%0d]", k),
                         64'(k < order.size() ? order[k] : -1), 64'(exp_order[k]));
        end
        wait_idle();

        // Directed products with nominal latency.
        do_op(0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 36, "neg_small");
        do_op(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 36, "min_sq");
        do_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0, 36, "neg1_sq");

        // Response back-pressure for 5 cycles with another requester waiting.
        rsp_ready = 1'b0;
        apply_stimulus(1, 32'd1000, 32'hFFFF_FFFE);
        wait_ready(1, t0);
        drop_req(1);
        req_valid[3]      = 1'b1;
        req_m[3*32 +: 32] = 32'd9;
        req_q[3*32 +: 32] = 32'd11;
        wait_rsp(t1);
        held = rsp_result;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            check_output($sformatf("stall%0d_valid", s), 64'(rsp_valid), 64'd1);
            check_output($sformatf("stall%0d_id", s), 64'(rsp_id), 64'd1);
            check_output($sformatf("stall%0d_result", s), rsp_result, 64'hFFFF_FFFF_FFFF_F830);
            check_output($sformatf("stall%0d_mul_en", s), 64'(mul_en), 64'd0);
            check_output($sformatf("stall%0d_req_ready", s), 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("stall_release_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check_output("post_stall_valid", 64'(rsp_valid), 64'd0);
        check_output("post_stall_busy", 64'(busy), 64'd0);
        check_output("post_stall_grant3", 64'(req_ready), 64'b1000);
        drop_req(3);
        wait_rsp(t1);
        check_output("req3_result", rsp_result, 64'd99);
        wait_idle();

        // Watchdog: done never arrives, then a normal request afterwards.
        stub_done_en = 1'b0;
        do_op(2, 32'd5, 32'd6, 64'd0, 1'b1, 43, "watchdog");
        stub_done_en = 1'b1;
        do_op(0, 32'h10, 32'h20, 64'h200, 1'b0, 36, "after_wd");

        // Done on the last permitted RUN cycle beats the watchdog.
        stub_done_at = TIMEOUT;
        do_op(3, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 64'hFFFF_FFFF_0000_0002, 1'b0, 43, "coincide");
        stub_done_at = 33;

        // Reset asserted between edges in the middle of RUN.
        apply_stimulus(2, 32'd3, 32'd4);
        wait_ready(2, t0);
        drop_req(2);
        repeat (10) @(posedge clk);
        #2;
        reset        = 1'b0;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        #1;
        check_output("midrun_busy", 64'(busy), 64'd0);
        check_output("midrun_mul_en", 64'(mul_en), 64'd0);
        check_output("midrun_req_ready", 64'(req_ready), 64'd0);
        check_output("midrun_mul_m", 64'(mul_m), 64'd0);
        check_output("midrun_rsp_result", rsp_result, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (req_ready != '0) begin
                    seen = 1'b1;
                    check_output("post_reset_first_grant", 64'(req_ready), 64'b0001);
                end
            end
            check_output("post_reset_grant_seen", 64'(seen), 64'd1);
        end
        drop_req(0);
        wait_ready(1, t0);
        drop_req(1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
